iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width in bits (power of 2, 8..64).
REQ-002 The block SHALL have parameter STEP, default 4, meaning the maximum bits shifted per cycle (power of 2, 1..WIDTH).
REQ-003 The block SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 The block SHALL have ports: start  in  1  request pulse; T  in  WIDTH  operand; FS  in  5  function select; shamnt  in  log2(WIDTH)  shift amount.
REQ-005 The block SHALL have ports: Y_lo  out  WIDTH  result; C, N, Z, V  out  1 each  flags; busy  out  1  operation in progress; done  out  1  one-cycle completion pulse; err  out  1  illegal FS on the accepted request.
REQ-006 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-007 FS encodings SHALL be SLL=5'h0C, SRL=5'h0D, SRA=5'h0E, ROL=5'h0F, ROR=5'h10; any other value is illegal.
REQ-008 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-009 start SHALL be accepted only in IDLE or DONE; T, FS, shamnt SHALL be captured on acceptance, and later input changes SHALL not affect the operation.
REQ-010 start in SHIFT SHALL be ignored: no capture, no state change, no extra done.
REQ-011 On acceptance with shamnt=0 or illegal FS, the FSM SHALL go to DONE; otherwise it SHALL go to SHIFT with remaining = shamnt.
REQ-012 Each SHIFT cycle SHALL shift by min(STEP, remaining) and decrement remaining by that amount; when remaining reaches 0, the next state SHALL be DONE.
REQ-013 Latency: with start accepted at edge k, done SHALL be high for exactly the cycle after edge k+1+ceil(shamnt/STEP); shamnt=0 gives done after edge k+1.
REQ-014 busy SHALL be high exactly while the state is SHIFT.
REQ-015 done SHALL be high only in DONE; DONE SHALL return to IDLE, or restart a new operation if start is asserted in DONE.
REQ-016 SLL and SRL SHALL zero-fill; SRA SHALL replicate captured T[WIDTH-1]; ROL/ROR SHALL rotate with no bit loss.
REQ-017 C SHALL be the last bit shifted out: SLL T[WIDTH-shamnt], SRL/SRA T[shamnt-1], ROL Y_lo[0], ROR Y_lo[WIDTH-1]; C=0 when shamnt=0.
REQ-018 N SHALL be Y_lo[WIDTH-1], Z SHALL be (Y_lo==0), and V SHALL be constant 0.
REQ-019 For illegal FS, Y_lo SHALL be captured T, C SHALL be 0, and err SHALL be high together with done; err SHALL be 0 otherwise.
REQ-020 Y_lo and flags SHALL be valid while done is high and SHALL hold until the next accepted start; during SHIFT they may show intermediate values.

Reset
REQ-021 While reset is high at a clock edge: state SHALL become IDLE; Y_lo, C, busy, done, err SHALL become 0; remaining SHALL become 0 (hence Z=1, N=0, V=0).
REQ-022 Reset SHALL abort any operation in progress with no done pulse; start sampled in the same cycle as reset SHALL be ignored.

Verification (WIDTH=32, STEP=4, start at edge k)
REQ-023 SLL, T=0x8000_0001, shamnt=1 -> done after edge k+2, Y_lo=0x0000_0002, C=1, N=0, Z=0.
REQ-024 SRA, T=0x8000_0000, shamnt=31 -> busy for 8 cycles, done after edge k+9, Y_lo=0xFFFF_FFFF, C=0, N=1.
REQ-025 SRL, T=0x0000_0001, shamnt=1 -> Y_lo=0, Z=1, C=1; then ROR, T=0x0000_0001, shamnt=4 -> Y_lo=0x1000_0000, C=0.
REQ-026 shamnt=0 with SLL, T=0x1234_5678 -> done after edge k+1, Y_lo=0x1234_5678, C=0; FS=5'h03 -> done after edge k+1, err=1, Y_lo=T.
REQ-027 start pulsed again mid-SHIFT with other operands -> ignored, original result returned; start in the DONE cycle -> new operation begins back-to-back.
REQ-028 Reset asserted mid-SHIFT -> next cycle IDLE, busy=0, done never pulses, Y_lo=0, Z=1.

Source files
------------

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter/rotator, up to STEP bits per cycle
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         T,
    input  logic [4:0]               FS,
    input  logic [$clog2(WIDTH)-1:0] shamnt,
    output logic [WIDTH-1:0]         Y_lo,
    output logic                     C,
    output logic                     N,
    output logic                     Z,
    output logic                     V,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = $clog2(WIDTH);
    // One extra bit so that WIDTH and STEP themselves are representable.
    localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);
    localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);

    localparam logic [4:0] FS_SLL = 5'h0C;
    localparam logic [4:0] FS_SRL = 5'h0D;
    localparam logic [4:0] FS_SRA = 5'h0E;
    localparam logic [4:0] FS_ROL = 5'h0F;
    localparam logic [4:0] FS_ROR = 5'h10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic            c_q, c_d;
    logic            err_q, err_d;
    logic [AW-1:0]   rem_q, rem_d;
    logic [4:0]      fs_q, fs_d;

    logic [AW:0]      rem_ext;
    logic [AW:0]      amt;
    logic [AW-1:0]    rem_next;
    logic [WIDTH-1:0] sll_y, srl_y, sra_y, rol_y, ror_y;
    logic [WIDTH-1:0] sll_out, sr_out;
    logic             fs_legal;

    // Per-cycle shift amount and the candidate results of one shift step.
    always_comb begin
        rem_ext  = {1'b0, rem_q};
        amt      = (rem_ext > STEP_W) ? STEP_W : rem_ext;
        rem_next = rem_q - amt[AW-1:0];
        sll_y    = y_q << amt;
        srl_y    = y_q >> amt;
        sra_y    = WIDTH'($signed(y_q) >>> amt);
        rol_y    = (y_q << amt) | (y_q >> (WIDTH_W - amt));
        ror_y    = (y_q >> amt) | (y_q << (WIDTH_W - amt));
        // Last bit leaving the word in this step; only meaningful for amt >= 1.
        sll_out  = y_q >> (WIDTH_W - amt);
        sr_out   = y_q >> (amt - 1'b1);
        fs_legal = (FS == FS_SLL) || (FS == FS_SRL) || (FS == FS_SRA) ||
                   (FS == FS_ROL) || (FS == FS_ROR);
    end

    // Next-state logic: capture on accepted start, then iterate until remaining is zero.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        c_d     = c_q;
        err_d   = err_q;
        rem_d   = rem_q;
        fs_d    = fs_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    y_d  = T;
                    c_d  = 1'b0;
                    fs_d = FS;
                    if (!fs_legal) begin
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else if (shamnt == '0) begin
                        err_d   = 1'b0;
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        rem_d   = shamnt;
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                case (fs_q)
                    FS_SLL: begin
                        y_d = sll_y;
                        c_d = sll_out[0];
                    end
                    FS_SRL: begin
                        y_d = srl_y;
                        c_d = sr_out[0];
                    end
                    FS_SRA: begin
                        y_d = sra_y;
                        c_d = sr_out[0];
                    end
                    FS_ROL: begin
                        y_d = rol_y;
                        c_d = rol_y[0];
                    end
                    default: begin
                        y_d = ror_y;
                        c_d = ror_y[WIDTH-1];
                    end
                endcase
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            fs_q    <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            c_q     <= c_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            fs_q    <= fs_d;
        end
    end

    // Outputs come straight from registers; err is only visible alongside done.
    always_comb begin
        Y_lo = y_q;
        C    = c_q;
        N    = y_q[WIDTH-1];
        Z    = (y_q == '0);
        V    = 1'b0;
        busy = (state_q == S_SHIFT);
        done = (state_q == S_DONE);
        err  = err_q && (state_q == S_DONE);
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb/tb_iter_shifter.sv - self-checking bench for iter_shifter
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] T;
    logic [4:0]  FS;
    logic [4:0]  shamnt;
    logic [31:0] Y_lo;
    logic        C, N, Z, V, busy, done, err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        n;
        logic        z;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .T      (T),
        .FS     (FS),
        .shamnt (shamnt),
        .Y_lo   (Y_lo),
        .C      (C),
        .N      (N),
        .Z      (Z),
        .V      (V),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [4:0] fs, input logic [31:0] t, input int sh);
        exp_t        r;
        logic [63:0] dbl;
        r.e   = 1'b0;
        r.c   = 1'b0;
        r.y   = t;
        r.lat = 0;
        dbl   = {t, t};
        if (!(fs inside {5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10})) begin
            r.e = 1'b1;
        end else if (sh != 0) begin
            r.lat = (sh + 3) / 4;
            case (fs)
                5'h0C: begin r.y = t << sh; r.c = t[32-sh]; end
                5'h0D: begin r.y = t >> sh; r.c = t[sh-1]; end
                5'h0E: begin r.y = $signed(t) >>> sh; r.c = t[sh-1]; end
                5'h0F: begin dbl = dbl << sh; r.y = dbl[63:32]; r.c = r.y[0]; end
                default: begin dbl = dbl >> sh; r.y = dbl[31:0]; r.c = r.y[31]; end
            endcase
        end
        r.n = r.y[31];
        r.z = (r.y == 32'h0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request right after an edge; it is sampled by the next edge.
    task automatic start_op(input logic [4:0] fs, input logic [31:0] t, input logic [4:0] sh, input bit push);
        start  = 1'b1;
        FS     = fs;
        T      = t;
        shamnt = sh;
        if (push) sbq.push_back(model(fs, t, int'(sh)));
    endtask

    // Follow the operation to done, optionally pulsing a stray start mid-SHIFT.
    task automatic wait_done(input string tag, input bit inject);
        int   n;
        int   busy_cnt;
        exp_t e;
        n = 0;
        busy_cnt = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                start  = 1'b0;
                T      = $urandom;
                FS     = 5'h0F;
                shamnt = 5'd7;
            end
            if (inject && n == 2) start_op(5'h10, 32'hDEAD_BEEF, 5'd3, 1'b0);
            if (inject && n == 3) start = 1'b0;
            if (busy && !done) busy_cnt++;
            if (done) break;
        end
        e = sbq.pop_front();
        chk({tag, "_latency"}, 64'(n), 64'(1 + e.lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
        chk({tag, "_Y"}, 64'(Y_lo), 64'(e.y));
        chk({tag, "_C"}, 64'(C), 64'(e.c));
        chk({tag, "_N"}, 64'(N), 64'(e.n));
        chk({tag, "_Z"}, 64'(Z), 64'(e.z));
        chk({tag, "_V"}, 64'(V), 64'(1'b0));
        chk({tag, "_err"}, 64'(err), 64'(e.e));
    endtask

    // One idle cycle: done drops, result is held.
    task automatic idle_chk(input string tag, input logic [31:0] y_hold);
        @(posedge clk);
        #1;
        chk({tag, "_idle_done"}, 64'(done), 64'(1'b0));
        chk({tag, "_idle_busy"}, 64'(busy), 64'(1'b0));
        chk({tag, "_idle_err"}, 64'(err), 64'(1'b0));
        chk({tag, "_idle_hold"}, 64'(Y_lo), 64'(y_hold));
    endtask

    initial begin
        logic [4:0] fs_tab [6];
        int         done_seen;
        fs_tab = '{5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h11};
        reset  = 1'b1;
        start  = 1'b1;
        T      = 32'hFFFF_FFFF;
        FS     = 5'h0C;
        shamnt = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_Y", 64'(Y_lo), 64'h0);
        chk("rst_C", 64'(C), 64'h0);
        chk("rst_N", 64'(N), 64'h0);
        chk("rst_Z", 64'(Z), 64'h1);
        chk("rst_V", 64'(V), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err), 64'h0);

        start_op(5'h0C, 32'h8000_0001, 5'd1, 1'b1);
        wait_done("sll1", 1'b0);
        idle_chk("sll1", 32'h0000_0002);

        start_op(5'h0E, 32'h8000_0000, 5'd31, 1'b1);
        wait_done("sra31", 1'b0);
        idle_chk("sra31", 32'hFFFF_FFFF);

        start_op(5'h0D, 32'h0000_0001, 5'd1, 1'b1);
        wait_done("srl1", 1'b0);
        start_op(5'h10, 32'h0000_0001, 5'd4, 1'b1);
        wait_done("ror4", 1'b0);
        idle_chk("ror4", 32'h1000_0000);

        start_op(5'h0C, 32'h1234_5678, 5'd0, 1'b1);
        wait_done("sh0", 1'b0);
        start_op(5'h03, 32'hCAFE_0001, 5'd5, 1'b1);
        wait_done("illegal", 1'b0);
        idle_chk("illegal", 32'hCAFE_0001);

        start_op(5'h0C, 32'hF0F0_1234, 5'd31, 1'b1);
        wait_done("inject", 1'b1);
        start_op(5'h0F, 32'h8000_0001, 5'd5, 1'b1);
        wait_done("b2b_rol", 1'b0);
        start_op(5'h0E, 32'h8765_4321, 5'd9, 1'b1);
        wait_done("b2b_sra", 1'b0);
        idle_chk("b2b_sra", 32'hFFC3_B2A1);

        for (int i = 0; i < 16; i++) begin
            start_op(fs_tab[$urandom_range(0, 5)], $urandom, 5'($urandom_range(0, 31)), 1'b1);
            wait_done("rand", 1'b0);
        end
        @(posedge clk);
        #1;

        start_op(5'h0D, 32'hFFFF_0000, 5'd31, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort_busy_before", 64'(busy), 64'h1);
        reset = 1'b1;
        start_op(5'h0C, 32'h0000_00FF, 5'd2, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_Y", 64'(Y_lo), 64'h0);
        chk("abort_Z", 64'(Z), 64'h1);
        chk("abort_N", 64'(N), 64'h0);
        chk("abort_C", 64'(C), 64'h0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'h0);
        chk("scoreboard_empty", 64'(sbq.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
